snake_body_stream: RTL and testbench
====================================

Name: snake_body_stream

Overview:
- Owns the snake body-segment memory (all segments except the head).
- Shifts it on every game move; grows it when the fruit is eaten.
- Streams one segment per clock to the graphic stage as (body_count, snake_body_x, snake_body_y) so that stage can rebuild its body copy.
- Scans the body against the current head to report self-collision to the game FSM. Sits between snake_game_fsm and graphic_game.

Parameters:
- SNAKE_LENGTH_BIT, 6, width of length/index; SNAKE_LENGTH_MAX = 2**SNAKE_LENGTH_BIT = 64.
- INIT_LEN, 2, body entries (excluding head) after reset/restart.
- START_X, 20, head column at reset; body[i] = (START_X-1-i, START_Y).
- START_Y, 40, head row at reset.

Ports:
- clock_25 in 1: 25 MHz pixel clock.
- reset in 1: asynchronous, active-low.
- restart in 1: synchronous reinitialisation, same values as reset.
- move_tick in 1: one-cycle pulse from FSM; the head is about to move.
- grow in 1: sampled with move_tick; lengthen by one.
- head_x in 7: current head column.
- head_y in 7: current head row.
- snake_length out SNAKE_LENGTH_BIT: number of valid body entries; tail = entry snake_length-1.
- length_max out 1: snake_length == SNAKE_LENGTH_MAX-1.
- body_count out SNAKE_LENGTH_BIT: index of the streamed entry.
- snake_body_x out 7: column of entry body_count.
- snake_body_y out 7: row of entry body_count.
- check_done out 1: one-cycle pulse; self_hit is valid.
- self_hit out 1: head overlaps a valid body entry; held until next check_done.

Behaviour:
- Storage: arrays bx/by [0..SNAKE_LENGTH_MAX-2], 63 entries × 7 bit. Unused entries hold OFF_GRID = 7'd127, which is outside the 124×81 grid.
- Reset/restart values:
  - snake_length = INIT_LEN, so length_max = 0.
  - Entries 0..INIT_LEN-1 = (START_X-1-i, START_Y); all others OFF_GRID.
  - body_count = 0; outputs snake_body_x/y = entry 0.
  - check_done = 0, self_hit = 0, scan FSM IDLE.
  - restart overrides move_tick in the same cycle.
- Move, on a clock edge with move_tick=1:
  - bx[0] <= head_x, by[0] <= head_y.
  - bx[i] <= bx[i-1] for i = 1..62.
  - If grow=1 and !length_max, snake_length += 1; the old tail survives at the new last index.
  - Otherwise length is unchanged and the old tail entry is overwritten with OFF_GRID.
  - grow with length_max=1 is ignored: no increment, no wrap.
- Stream:
  - body_count increments every cycle 0..62, then wraps to 0. Value 63 is never emitted.
  - snake_body_x/y are registered and aligned with body_count: on the same edge, data <= array[next_count].
  - Entries updated by a move become visible from the next streamed index onward. A full refresh takes 63 cycles, well within one frame.
- Scan FSM (states IDLE, WAIT0, SCAN, DONE):
  - IDLE -> WAIT0 on move_tick.
  - WAIT0 -> SCAN when next_count == 0.
  - SCAN compares each streamed entry with index < snake_length to (head_x, head_y) and ORs the result into a hit accumulator. It leaves SCAN after index 62.
  - DONE lasts one cycle: check_done = 1, self_hit <= accumulator, then IDLE.
  - A move_tick in WAIT0, SCAN or DONE clears the accumulator and returns to WAIT0, i.e. the check restarts. check_done never pulses for the aborted scan.
  - Worst-case latency from move_tick to check_done: 127 cycles.
  - head_x/head_y are expected stable between move_tick and check_done.
- Arithmetic: all index comparisons unsigned, SNAKE_LENGTH_BIT wide; no coordinate arithmetic except the reset initialisation.

Optional Feature:
- Macro: SNAKE_SELF_HIT_EN.
- Defined: scan FSM and comparators are compiled in, with behaviour as above.
- Undefined: no scan logic. self_hit is constant 0, and check_done pulses exactly one cycle after each move_tick.

Decomposition:
- Shared package: SNAKE_LENGTH_BIT, SNAKE_LENGTH_MAX, coordinate width 7, OFF_GRID, GRID_W=124, GRID_H=81, START_X/START_Y defaults, scan-state encoding.
- One sub-module: body_collision_scan. It takes the streamed entry, body_count, snake_length, head and move_tick, and produces check_done and self_hit. It is instantiated only under SNAKE_SELF_HIT_EN.

Test Plan:
- Reset, then free-run 63 cycles -> body_count sequence 0..62,0. Entry 0 = (19,40), entry 1 = (18,40), entries 2..62 = (127,127). snake_length=2.
- head=(20,40), move_tick grow=0 -> next sweep shows entry0=(20,40), entry1=(19,40), entry2=(127,127). snake_length=2.
- head=(21,40), move_tick grow=1 -> entry0=(21,40), entry1=(20,40), entry2=(19,40). snake_length=3.
- Grow to 63, then move_tick grow=1 -> length_max=1, snake_length stays 63, shift still occurs.
- Head set equal to entry 1 after a move -> check_done within ≤127 cycles with self_hit=1. Head off-body -> self_hit=0. A second move_tick mid-SCAN -> only one check_done pulse.
- Async reset asserted mid-SCAN; separately restart with move_tick in the same cycle -> state equals the post-reset values, no check_done pulse, body_count=0.

Source files
------------

// File: rtl/snake_body_stream_pkg.sv
// Shared constants and scan-state encoding for the snake body-segment stream.
// Used by snake_body_stream and body_collision_scan.
package snake_body_stream_pkg;

   localparam int COORD_W        = 7;
   localparam int DEF_LENGTH_BIT = 6;
   localparam int DEF_LENGTH_MAX = 2 ** DEF_LENGTH_BIT;
   localparam int DEF_INIT_LEN   = 2;
   localparam int DEF_START_X    = 20;
   localparam int DEF_START_Y    = 40;
   localparam int GRID_W         = 124;
   localparam int GRID_H         = 81;

   typedef logic [COORD_W-1:0] coord_t;

   // Column/row value that no on-grid head can ever reach.
   localparam coord_t OFF_GRID = 7'd127;

   typedef enum logic [1:0] {
      SCAN_IDLE  = 2'd0,
      SCAN_WAIT0 = 2'd1,
      SCAN_RUN   = 2'd2,
      SCAN_DONE  = 2'd3
   } scan_state_t;

endpackage

// File: rtl/body_collision_scan.sv
// Self-collision scanner: waits for the start of a fresh stream sweep after a move,
// compares every valid streamed entry against the head and reports once per move.
module body_collision_scan
   import snake_body_stream_pkg::*;
#(
   parameter int SNAKE_LENGTH_BIT = DEF_LENGTH_BIT
) (
   input  logic                        clock_25,
   input  logic                        reset,
   input  logic                        restart,
   input  logic                        move_tick,
   input  logic [SNAKE_LENGTH_BIT-1:0] body_count,
   input  logic [SNAKE_LENGTH_BIT-1:0] snake_length,
   input  logic [COORD_W-1:0]          body_x,
   input  logic [COORD_W-1:0]          body_y,
   input  logic [COORD_W-1:0]          head_x,
   input  logic [COORD_W-1:0]          head_y,
   output logic                        check_done,
   output logic                        self_hit
);

   localparam logic [SNAKE_LENGTH_BIT-1:0] LAST_IDX =
      SNAKE_LENGTH_BIT'(2 ** SNAKE_LENGTH_BIT - 2);

   scan_state_t state_q;
   logic        hit_acc_q;
   logic        check_done_q;
   logic        self_hit_q;
   logic        entry_hit;
   logic        last_entry;

   always_comb begin
      entry_hit  = (body_count < snake_length) && (body_x == head_x) && (body_y == head_y);
      last_entry = (body_count == LAST_IDX);
   end

   // A new move always restarts the check, so an in-flight scan never reports.
   always_ff @(posedge clock_25 or negedge reset) begin
      if (!reset) begin
         state_q      <= SCAN_IDLE;
         hit_acc_q    <= 1'b0;
         check_done_q <= 1'b0;
         self_hit_q   <= 1'b0;
      end else if (restart) begin
         state_q      <= SCAN_IDLE;
         hit_acc_q    <= 1'b0;
         check_done_q <= 1'b0;
         self_hit_q   <= 1'b0;
      end else begin
         check_done_q <= 1'b0;
         if (move_tick) begin
            state_q   <= SCAN_WAIT0;
            hit_acc_q <= 1'b0;
         end else begin
            case (state_q)
               SCAN_IDLE: state_q <= SCAN_IDLE;
               SCAN_WAIT0: begin
                  if (last_entry) state_q <= SCAN_RUN;
               end
               SCAN_RUN: begin
                  if (last_entry) begin
                     state_q      <= SCAN_DONE;
                     check_done_q <= 1'b1;
                     self_hit_q   <= hit_acc_q | entry_hit;
                  end else begin
                     hit_acc_q <= hit_acc_q | entry_hit;
                  end
               end
               SCAN_DONE: state_q <= SCAN_IDLE;
               default:   state_q <= SCAN_IDLE;
            endcase
         end
      end
   end

   assign check_done = check_done_q;
   assign self_hit   = self_hit_q;

endmodule

// File: rtl/snake_body_stream.sv
// Snake body memory: shifts on move, grows on fruit, streams one entry per clock.
// Optional macro SNAKE_SELF_HIT_EN compiles in the self-collision scanner.
module snake_body_stream
   import snake_body_stream_pkg::*;
#(
   parameter int SNAKE_LENGTH_BIT = DEF_LENGTH_BIT,
   parameter int INIT_LEN         = DEF_INIT_LEN,
   parameter int START_X          = DEF_START_X,
   parameter int START_Y          = DEF_START_Y
) (
   input  logic                        clock_25,
   input  logic                        reset,
   input  logic                        restart,
   input  logic                        move_tick,
   input  logic                        grow,
   input  logic [COORD_W-1:0]          head_x,
   input  logic [COORD_W-1:0]          head_y,
   output logic [SNAKE_LENGTH_BIT-1:0] snake_length,
   output logic                        length_max,
   output logic [SNAKE_LENGTH_BIT-1:0] body_count,
   output logic [COORD_W-1:0]          snake_body_x,
   output logic [COORD_W-1:0]          snake_body_y,
   output logic                        check_done,
   output logic                        self_hit
);

   localparam int SNAKE_LENGTH_MAX = 2 ** SNAKE_LENGTH_BIT;
   localparam int BODY_DEPTH       = SNAKE_LENGTH_MAX - 1;

   localparam logic [SNAKE_LENGTH_BIT-1:0] LAST_IDX   = SNAKE_LENGTH_BIT'(BODY_DEPTH - 1);
   localparam logic [SNAKE_LENGTH_BIT-1:0] FULL_LEN   = SNAKE_LENGTH_BIT'(BODY_DEPTH);
   localparam logic [SNAKE_LENGTH_BIT-1:0] INIT_LEN_W = SNAKE_LENGTH_BIT'(INIT_LEN);
   localparam logic [SNAKE_LENGTH_BIT-1:0] ONE_W      = SNAKE_LENGTH_BIT'(1);

   coord_t                      bx_q [BODY_DEPTH];
   coord_t                      bx_d [BODY_DEPTH];
   coord_t                      by_q [BODY_DEPTH];
   coord_t                      by_d [BODY_DEPTH];
   logic [SNAKE_LENGTH_BIT-1:0] length_q;
   logic [SNAKE_LENGTH_BIT-1:0] length_d;
   logic [SNAKE_LENGTH_BIT-1:0] count_q;
   logic [SNAKE_LENGTH_BIT-1:0] count_d;
   coord_t                      body_x_q;
   coord_t                      body_x_d;
   coord_t                      body_y_q;
   coord_t                      body_y_d;
   logic                        length_full;

   // Initial body lies horizontally to the left of the start head.
   function automatic coord_t init_x(input int idx);
      return (idx < INIT_LEN) ? coord_t'(START_X - 1 - idx) : OFF_GRID;
   endfunction

   function automatic coord_t init_y(input int idx);
      return (idx < INIT_LEN) ? coord_t'(START_Y) : OFF_GRID;
   endfunction

   assign length_full = (length_q == FULL_LEN);

   always_comb begin
      count_d  = (count_q == LAST_IDX) ? '0 : count_q + ONE_W;
      length_d = length_q;
      bx_d     = bx_q;
      by_d     = by_q;
      // Stream reads the pre-move array; move results appear from the next index.
      body_x_d = bx_q[count_d];
      body_y_d = by_q[count_d];

      if (restart) begin
         count_d  = '0;
         length_d = INIT_LEN_W;
         for (int i = 0; i < BODY_DEPTH; i++) begin
            bx_d[i] = init_x(i);
            by_d[i] = init_y(i);
         end
         body_x_d = init_x(0);
         body_y_d = init_y(0);
      end else if (move_tick) begin
         bx_d[0] = head_x;
         by_d[0] = head_y;
         for (int i = 1; i < BODY_DEPTH; i++) begin
            bx_d[i] = bx_q[i-1];
            by_d[i] = by_q[i-1];
         end
         // The shifted old tail now sits at index length_q: keep it to grow, else erase it.
         if (grow && !length_full) begin
            length_d = length_q + ONE_W;
         end else if (!length_full) begin
            bx_d[length_q] = OFF_GRID;
            by_d[length_q] = OFF_GRID;
         end
      end
   end

   always_ff @(posedge clock_25 or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < BODY_DEPTH; i++) begin
            bx_q[i] <= init_x(i);
            by_q[i] <= init_y(i);
         end
         length_q <= INIT_LEN_W;
         count_q  <= '0;
         body_x_q <= init_x(0);
         body_y_q <= init_y(0);
      end else begin
         bx_q     <= bx_d;
         by_q     <= by_d;
         length_q <= length_d;
         count_q  <= count_d;
         body_x_q <= body_x_d;
         body_y_q <= body_y_d;
      end
   end

   assign snake_length = length_q;
   assign length_max   = length_full;
   assign body_count   = count_q;
   assign snake_body_x = body_x_q;
   assign snake_body_y = body_y_q;

`ifdef SNAKE_SELF_HIT_EN
   body_collision_scan #(
      .SNAKE_LENGTH_BIT(SNAKE_LENGTH_BIT)
   ) u_scan (
      .clock_25    (clock_25),
      .reset       (reset),
      .restart     (restart),
      .move_tick   (move_tick),
      .body_count  (count_q),
      .snake_length(length_q),
      .body_x      (body_x_q),
      .body_y      (body_y_q),
      .head_x      (head_x),
      .head_y      (head_y),
      .check_done  (check_done),
      .self_hit    (self_hit)
   );
`else
   logic check_done_q;
   logic check_done_d;

   // Without the scanner the FSM still gets its handshake one cycle after each move.
   always_comb check_done_d = move_tick & ~restart;

   always_ff @(posedge clock_25 or negedge reset) begin
      if (!reset) check_done_q <= 1'b0;
      else        check_done_q <= check_done_d;
   end

   assign check_done = check_done_q;
   assign self_hit   = 1'b0;
`endif

endmodule

// File: tb/tb_snake_body_stream.sv
// Self-checking bench for snake_body_stream: queue-based body model, vector table,
// randomized moves, and hand sequences for growth limit, scan and reset corners.
module tb_snake_body_stream;

   localparam logic [6:0] OFF = 7'd127;

   logic       clock_25 = 1'b0;
   logic       reset = 1'b0;
   logic       restart = 1'b0;
   logic       move_tick = 1'b0;
   logic       grow = 1'b0;
   logic [6:0] head_x = 7'd20;
   logic [6:0] head_y = 7'd40;
   logic [5:0] snake_length;
   logic       length_max;
   logic [5:0] body_count;
   logic [6:0] snake_body_x;
   logic [6:0] snake_body_y;
   logic       check_done;
   logic       self_hit;

   snake_body_stream dut (
      .clock_25    (clock_25),
      .reset       (reset),
      .restart     (restart),
      .move_tick   (move_tick),
      .grow        (grow),
      .head_x      (head_x),
      .head_y      (head_y),
      .snake_length(snake_length),
      .length_max  (length_max),
      .body_count  (body_count),
      .snake_body_x(snake_body_x),
      .snake_body_y(snake_body_y),
      .check_done  (check_done),
      .self_hit    (self_hit)
   );

   always #20 clock_25 = ~clock_25;

   int          n_cmp = 0;
   int          n_fail = 0;
   logic [13:0] body_q[$];
   int          mcnt = 0;
   int          cd_count = 0;
   bit          exp_cd = 1'b0;
   logic [13:0] seen[64];

   typedef struct {
      logic            g;
      logic [6:0]      hx;
      logic [6:0]      hy;
      int              len;
      logic [0:2][13:0] e;
   } vec_t;

   vec_t vecs[4];

   task automatic check(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference body: front = entry 0, size = snake length.
   task automatic model_init();
      body_q.delete();
      for (int i = 0; i < 2; i++) body_q.push_back({7'(20 - 1 - i), 7'd40});
   endtask

   task automatic model_move(input logic [6:0] hx, input logic [6:0] hy, input logic g);
      body_q.push_front({hx, hy});
      if (!(g && body_q.size() <= 63)) void'(body_q.pop_back());
   endtask

   function automatic logic [13:0] entry(input int i);
      return (i < body_q.size()) ? body_q[i] : {OFF, OFF};
   endfunction

   function automatic bit model_hit(input logic [6:0] hx, input logic [6:0] hy);
      foreach (body_q[i]) if (body_q[i] == {hx, hy}) return 1'b1;
      return 1'b0;
   endfunction

   // One clock: predict from the model, advance the DUT, compare the stream.
   task automatic step();
      logic [13:0] e;
      int          nc;
      exp_cd = 1'b0;
      if (restart) begin
         model_init();
         nc = 0;
         e  = entry(0);
      end else begin
         nc     = (mcnt == 62) ? 0 : mcnt + 1;
         e      = entry(nc);
         exp_cd = move_tick;
         if (move_tick) model_move(head_x, head_y, grow);
      end
      @(posedge clock_25);
      #1;
      mcnt = nc;
      if (check_done) cd_count++;
      check("body_count", body_count, nc);
      check("body_x", snake_body_x, e[13:7]);
      check("body_y", snake_body_y, e[6:0]);
      check("snake_length", snake_length, body_q.size());
      check("length_max", length_max, body_q.size() == 63);
`ifndef SNAKE_SELF_HIT_EN
      check("check_done", check_done, exp_cd);
      check("self_hit", self_hit, 0);
`endif
   endtask

   task automatic do_move(input logic [6:0] hx, input logic [6:0] hy, input logic g);
      head_x = hx; head_y = hy; grow = g; move_tick = 1'b1;
      step();
      move_tick = 1'b0; grow = 1'b0;
   endtask

   task automatic check_reset_state(input string tag);
      check({tag, "_count"}, body_count, 0);
      check({tag, "_x"}, snake_body_x, 19);
      check({tag, "_y"}, snake_body_y, 40);
      check({tag, "_len"}, snake_length, 2);
      check({tag, "_lmax"}, length_max, 0);
      check({tag, "_cd"}, check_done, 0);
      check({tag, "_hit"}, self_hit, 0);
   endtask

`ifdef SNAKE_SELF_HIT_EN
   // Run a fixed window, expect exactly one pulse within 127 cycles and the given hit.
   task automatic expect_one_done(input string tag, input int start_cd, input bit exp_hit);
      int lat;
      lat = -1;
      for (int i = 1; i <= 140; i++) begin
         step();
         if (lat < 0 && cd_count != start_cd) lat = i;
      end
      check({tag, "_pulses"}, cd_count - start_cd, 1);
      check({tag, "_latency_ok"}, (lat > 0 && lat <= 127), 1);
      check({tag, "_self_hit"}, self_hit, exp_hit);
      check({tag, "_self_hit_model"}, self_hit, model_hit(head_x, head_y));
   endtask
`endif

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int cd_before;
      int seen30;

      vecs[0] = '{g: 1'b0, hx: 7'd20, hy: 7'd40, len: 2,
                  e: {{7'd20, 7'd40}, {7'd19, 7'd40}, {OFF, OFF}}};
      vecs[1] = '{g: 1'b1, hx: 7'd21, hy: 7'd40, len: 3,
                  e: {{7'd21, 7'd40}, {7'd20, 7'd40}, {7'd19, 7'd40}}};
      vecs[2] = '{g: 1'b0, hx: 7'd21, hy: 7'd41, len: 3,
                  e: {{7'd21, 7'd41}, {7'd21, 7'd40}, {7'd20, 7'd40}}};
      vecs[3] = '{g: 1'b1, hx: 7'd22, hy: 7'd41, len: 4,
                  e: {{7'd22, 7'd41}, {7'd21, 7'd41}, {7'd21, 7'd40}}};

      reset = 1'b0;
      #50;
      check_reset_state("reset");
      #15 reset = 1'b1;
      model_init();
      mcnt = 0;

      // Free-running sweep after reset, then wrap back to index 0.
      repeat (63) step();
      check("sweep_wrap_count", body_count, 0);

      foreach (vecs[v]) begin
         do_move(vecs[v].hx, vecs[v].hy, vecs[v].g);
         for (int c = 0; c < 63; c++) begin
            step();
            seen[body_count] = {snake_body_x, snake_body_y};
         end
         check($sformatf("vec%0d_len", v), snake_length, vecs[v].len);
         for (int k = 0; k < 3; k++)
            check($sformatf("vec%0d_entry%0d", v, k), seen[k], vecs[v].e[k]);
      end

      // Grow to the limit, then a grow at the limit must only shift.
      for (int i = 0; i < 70 && body_q.size() < 63; i++) begin
         do_move(7'($urandom_range(0, 123)), 7'($urandom_range(0, 80)), 1'b1);
         step();
      end
      check("len_at_max", snake_length, 63);
      check("lmax_at_max", length_max, 1);
      do_move(7'd5, 7'd6, 1'b1);
      check("len_grow_at_max", snake_length, 63);
      check("lmax_grow_at_max", length_max, 1);
      repeat (63) step();
      do_move(7'd7, 7'd8, 1'b0);
      repeat (64) step();
      check("len_shift_at_max", snake_length, 63);

      for (int i = 0; i < 400; i++) begin
         restart   = ($urandom_range(0, 99) == 0);
         move_tick = ($urandom_range(0, 5) == 0);
         grow      = $urandom_range(0, 1);
         head_x    = 7'($urandom_range(0, 123));
         head_y    = 7'($urandom_range(0, 80));
         step();
      end
      restart = 1'b0; move_tick = 1'b0; grow = 1'b0;

      // Restart wins over a simultaneous move.
      restart = 1'b1; move_tick = 1'b1; grow = 1'b1; head_x = 7'd90; head_y = 7'd9;
      step();
      restart = 1'b0; move_tick = 1'b0; grow = 1'b0;
      check_reset_state("restart");
      cd_before = cd_count;
      repeat (140) step();
      check("restart_no_done", cd_count - cd_before, 0);

`ifdef SNAKE_SELF_HIT_EN
      cd_before = cd_count;
      do_move(7'd20, 7'd40, 1'b0);
      head_x = 7'd19; head_y = 7'd40;
      expect_one_done("hit_entry1", cd_before, 1'b1);

      cd_before = cd_count;
      do_move(7'd60, 7'd30, 1'b0);
      head_x = 7'd100; head_y = 7'd70;
      expect_one_done("off_body", cd_before, 1'b0);

      for (int i = 0; i < 70 && body_count != 5; i++) step();
      check("sync_count5", body_count, 5);
      cd_before = cd_count;
      do_move(7'd70, 7'd20, 1'b0);
      head_x = 7'd60; head_y = 7'd30;
      seen30 = 0;
      for (int i = 0; i < 200 && seen30 < 2; i++) begin
         step();
         if (body_count == 30) seen30++;
      end
      check("reach_mid_scan", seen30, 2);
      check("no_done_before_abort", cd_count - cd_before, 0);
      do_move(7'd80, 7'd20, 1'b0);
      head_x = 7'd100; head_y = 7'd70;
      expect_one_done("abort_rescan", cd_before, 1'b0);
`endif

      // Asynchronous reset in the middle of a scan.
      do_move(7'd30, 7'd30, 1'b1);
      head_x = 7'd29; head_y = 7'd30;
      repeat (80) step();
      #3 reset = 1'b0;
      #1;
      check_reset_state("async_reset");
      @(posedge clock_25);
      #1;
      check_reset_state("async_reset_held");
      #5 reset = 1'b1;
      model_init();
      mcnt = 0;
      cd_before = cd_count;
      repeat (140) step();
      check("reset_no_done", cd_count - cd_before, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
